// File: rtl/audio_pkg.sv
// Shared types and default sizing for the audio double-buffer scheduler.
package audio_pkg;
  localparam int DEFAULT_BUF_SIZE    = 32;
  localparam int DEFAULT_SAMPLE_BITS = 16;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_FILL = 1'b1
  } fill_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_SEND = 2'd1,
    D_DONE = 2'd2
  } drain_state_t;
endpackage

// File: rtl/audio_bank_ram.sv
// Two-bank byte RAM: one write port, one registered read port, addressed {bank, index}.
module audio_bank_ram
  import audio_pkg::*;
#(
  parameter int BUF_SIZE = DEFAULT_BUF_SIZE,
  parameter int IDX_W    = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic             wbank_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [7:0]       wdata_i,
  input  logic             rbank_i,
  input  logic [IDX_W-1:0] ridx_i,
  output logic [7:0]       rdata_o
);
  logic [7:0] mem_q [2][BUF_SIZE];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i && (32'(widx_i) < BUF_SIZE)) mem_q[wbank_i][widx_i] <= wdata_i;
  end

  // Out-of-range prefetch addresses (past the last index) just hold the last read.
  always_ff @(posedge clk) begin
    if (32'(ridx_i) < BUF_SIZE) rdata_q <= mem_q[rbank_i][ridx_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/audio_buffer_scheduler.sv
// Ping-pong scheduler: fills one bank from DSP samples while the other drains bytewise to a UART.
module audio_buffer_scheduler
  import audio_pkg::*;
#(
  parameter int BUF_SIZE    = DEFAULT_BUF_SIZE,
  parameter int SAMPLE_BITS = DEFAULT_SAMPLE_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_tick,
  input  logic                          dsp_tick,
  input  logic signed [SAMPLE_BITS-1:0] sample_in,
  output logic                          dsp_en,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [7:0]                    tx_byte,
  output logic [7:0]                    frame_count,
  output logic [7:0]                    overrun_count
);
  localparam int IDX_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_SIZE - 1);

  // Arithmetic shift by SAMPLE_BITS-8 truncated to 8 bits keeps exactly the top byte.
  function automatic logic [7:0] to_byte(input logic signed [SAMPLE_BITS-1:0] s);
    return s[SAMPLE_BITS-1 -: 8];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  fill_state_t  fill_state_q, fill_state_d;
  drain_state_t drain_state_q, drain_state_d;
  logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]       full_q, full_d;
  logic             dsp_en_q, dsp_en_d, tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q, tx_byte_d, frame_cnt_q, frame_cnt_d, overrun_q, overrun_d;
  logic             ram_we, fill_done, drain_done;
  logic [IDX_W-1:0] ram_ridx;
  logic [7:0]       ram_rdata;

  always_comb begin
    fill_state_d = fill_state_q;
    fill_cnt_d   = fill_cnt_q;
    wr_bank_d    = wr_bank_q;
    dsp_en_d     = dsp_en_q;
    overrun_d    = overrun_q;
    ram_we       = 1'b0;
    fill_done    = 1'b0;
    case (fill_state_q)
      F_IDLE: begin
        if (frame_tick) begin
          if (full_q[wr_bank_q]) begin
            overrun_d = sat_inc8(overrun_q);
          end else begin
            fill_state_d = F_FILL;
            fill_cnt_d   = '0;
            dsp_en_d     = 1'b1;
          end
        end
      end
      F_FILL: begin
        if (dsp_tick) begin
          ram_we     = 1'b1;
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == LAST_IDX) begin
            fill_done    = 1'b1;
            wr_bank_d    = ~wr_bank_q;
            dsp_en_d     = 1'b0;
            fill_state_d = F_IDLE;
          end
        end
      end
      default: fill_state_d = F_IDLE;
    endcase
  end

  always_comb begin
    drain_state_d = drain_state_q;
    rd_cnt_d      = rd_cnt_q;
    rd_bank_d     = rd_bank_q;
    tx_valid_d    = tx_valid_q;
    tx_byte_d     = tx_byte_q;
    frame_cnt_d   = frame_cnt_q;
    drain_done    = 1'b0;
    case (drain_state_q)
      D_IDLE: begin
        if (full_q[rd_bank_q]) begin
          drain_state_d = D_SEND;
          rd_cnt_d      = '0;
          tx_valid_d    = 1'b0;
        end
      end
      D_SEND: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_byte_d  = ram_rdata;
        end else if (tx_ready) begin
          if (rd_cnt_q == LAST_IDX) begin
            drain_done    = 1'b1;
            rd_bank_d     = ~rd_bank_q;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            tx_valid_d    = 1'b0;
            drain_state_d = D_DONE;
          end else begin
            rd_cnt_d  = rd_cnt_q + 1'b1;
            tx_byte_d = ram_rdata;
          end
        end
      end
      D_DONE:  drain_state_d = D_IDLE;
      default: drain_state_d = D_IDLE;
    endcase
    // RAM always prefetches the byte after the one that will be on tx_byte next cycle.
    ram_ridx = (drain_state_q == D_SEND) ? rd_cnt_d + 1'b1 : '0;
  end

  always_comb begin
    full_d = full_q;
    if (fill_done)  full_d[wr_bank_q] = 1'b1;
    if (drain_done) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_state_q  <= F_IDLE;
      drain_state_q <= D_IDLE;
      fill_cnt_q    <= '0;
      rd_cnt_q      <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= 2'b00;
      dsp_en_q      <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= 8'd0;
      frame_cnt_q   <= 8'd0;
      overrun_q     <= 8'd0;
    end else begin
      fill_state_q  <= fill_state_d;
      drain_state_q <= drain_state_d;
      fill_cnt_q    <= fill_cnt_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      dsp_en_q      <= dsp_en_d;
      tx_valid_q    <= tx_valid_d;
      tx_byte_q     <= tx_byte_d;
      frame_cnt_q   <= frame_cnt_d;
      overrun_q     <= overrun_d;
    end
  end

  audio_bank_ram #(.BUF_SIZE(BUF_SIZE), .IDX_W(IDX_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .wbank_i (wr_bank_q),
    .widx_i  (fill_cnt_q),
    .wdata_i (to_byte(sample_in)),
    .rbank_i (rd_bank_q),
    .ridx_i  (ram_ridx),
    .rdata_o (ram_rdata)
  );

  assign dsp_en        = dsp_en_q;
  assign tx_valid      = tx_valid_q;
  assign tx_byte       = tx_byte_q;
  assign frame_count   = frame_cnt_q;
  assign overrun_count = overrun_q;
endmodule
